// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window scheduler family.
package conv_pkg;

    localparam int DEFAULT_WIDTH_BIT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_PUSH,
        ST_DONE
    } state_t;

    // Number of window positions along one edge of the output map.
    function automatic int out_size_f(input int size, input int sizeker, input int stride);
        return (size - sizeker) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_window_counter.sv
// Raster row/col counter over an OUT_SIZE x OUT_SIZE output map.
// Exposes next-state values so the owner can register derived outputs
// in the same cycle the counter moves.
module conv_window_counter #(
    parameter int OUT_SIZE = 5,
    parameter int IDX_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] row_next_o,
    output logic [IDX_W-1:0] col_next_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(OUT_SIZE - 1);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    // Next-state: clear has priority, otherwise step in raster order.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == MAX_IDX) begin
                col_d = '0;
                row_d = row_q + IDX_W'(1);
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_next_o = row_d;
    assign col_next_o = col_d;
    assign last_o     = (row_q == MAX_IDX) && (col_q == MAX_IDX);

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences a shared SIZEKER x SIZEKER conv engine over a SIZE x SIZE map:
// load window, fire engine, wait for result (with timeout), push to sink.
// Optional macro CONV_SCHED_PERF_EN adds a saturating stall_cycles counter.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int SIZE      = 7,
    parameter int SIZEKER   = 3,
    parameter int STRIDE    = 1,
    parameter int WIDTH_BIT = DEFAULT_WIDTH_BIT,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [$clog2(SIZE)-1:0]  win_row,
    output logic [$clog2(SIZE)-1:0]  win_col,
    output logic                     win_load,
    output logic                     eng_start,
    input  logic                     eng_valid,
    input  logic [WIDTH_BIT-1:0]     eng_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(SIZE)-1:0]  out_row,
    output logic [$clog2(SIZE)-1:0]  out_col,
    output logic [WIDTH_BIT-1:0]     out_data
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int OUT_SIZE = out_size_f(SIZE, SIZEKER, STRIDE);
    localparam int IDX_W    = $clog2(SIZE);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 busy_q, done_q, error_q, error_d;
    logic                 win_load_q, eng_start_q, out_valid_q;
    logic [IDX_W-1:0]     win_row_q, win_col_q, out_row_q, out_col_q;
    logic [WIDTH_BIT-1:0] out_data_q, out_data_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic                 cnt_clear, cnt_advance, cnt_last;
    logic [IDX_W-1:0]     row_next, col_next;

    conv_window_counter #(
        .OUT_SIZE (OUT_SIZE),
        .IDX_W    (IDX_W)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .advance_i  (cnt_advance),
        .row_next_o (row_next),
        .col_next_o (col_next),
        .last_o     (cnt_last)
    );

    // FSM next-state, counter control, timeout and result capture.
    always_comb begin
        state_d     = state_q;
        error_d     = error_q;
        tmo_d       = tmo_q;
        out_data_d  = out_data_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    error_d   = 1'b0;
                    cnt_clear = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_FIRE;
            ST_FIRE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_valid) begin
                    out_data_d = eng_result;
                    state_d    = ST_PUSH;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_PUSH: begin
                if (out_ready) begin
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_advance = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; strobes are aligned with the state they belong to,
    // while done is issued from the DONE state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            win_load_q  <= 1'b0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_data_q  <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q      <= (state_q == ST_DONE);
            error_q     <= error_d;
            win_load_q  <= (state_d == ST_LOAD);
            eng_start_q <= (state_d == ST_FIRE);
            out_valid_q <= (state_d == ST_PUSH);
            win_row_q   <= IDX_W'(int'(row_next) * STRIDE);
            win_col_q   <= IDX_W'(int'(col_next) * STRIDE);
            out_row_q   <= row_next;
            out_col_q   <= col_next;
            out_data_q  <= out_data_d;
            tmo_q       <= tmo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign win_load  = win_load_q;
    assign eng_start = eng_start_q;
    assign out_valid = out_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_data  = out_data_q;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of engine-wait cycles plus sink back-pressure cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            stall_q <= '0;
        end else if (((state_q == ST_WAIT) || ((state_q == ST_PUSH) && !out_ready))
                     && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: three instances (7/3/1, 7/3/2, 3/3/1, TIMEOUT=10),
// an engine model per instance feeding a scoreboard, a table of full passes,
// and hand sequences for sink stall and mid-pass reset.
module tb_conv_window_scheduler;

    logic clk;
    logic rst;

    logic [2:0] start_a, out_ready_a, mute_a;
    logic [2:0] busy_a, done_a, error_a, win_load_a, eng_start_a, out_valid_a;
    logic [2:0][2:0] wrow_a, wcol_a, orow_a, ocol_a;
    logic [2:0][7:0] odata_a;

    int nchk = 0;
    int nerr = 0;
    int out_cnt [3];

    typedef struct {
        int inst;
        bit mute;
        int exp_lat;
        int exp_outs;
        bit exp_err;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int SZ  = (gi == 2) ? 3 : 7;
        localparam int STR = (gi == 1) ? 2 : 1;
        localparam int OS  = (SZ - 3) / STR + 1;
        localparam int IW  = $clog2(SZ);

        typedef struct packed {
            logic [7:0] r;
            logic [7:0] c;
            logic [7:0] d;
        } exp_t;

        logic          busy_g, done_g, error_g, win_load_g, eng_start_g, out_valid_g;
        logic          eng_valid_g;
        logic [7:0]    eng_result_g, out_data_g;
        logic [IW-1:0] win_row_g, win_col_g, out_row_g, out_col_g;
        exp_t          sb_q [$];
`ifdef CONV_SCHED_PERF_EN
        logic [31:0]   stall_g;
`endif

        conv_window_scheduler #(
            .SIZE      (SZ),
            .SIZEKER   (3),
            .STRIDE    (STR),
            .WIDTH_BIT (8),
            .TIMEOUT   (10)
        ) u_dut (
            .clock      (clk),
            .reset      (rst),
            .start      (start_a[gi]),
            .busy       (busy_g),
            .done       (done_g),
            .error      (error_g),
            .win_row    (win_row_g),
            .win_col    (win_col_g),
            .win_load   (win_load_g),
            .eng_start  (eng_start_g),
            .eng_valid  (eng_valid_g),
            .eng_result (eng_result_g),
            .out_valid  (out_valid_g),
            .out_ready  (out_ready_a[gi]),
            .out_row    (out_row_g),
            .out_col    (out_col_g),
            .out_data   (out_data_g)
`ifdef CONV_SCHED_PERF_EN
            ,
            .stall_cycles (stall_g)
`endif
        );

        assign busy_a[gi]      = busy_g;
        assign done_a[gi]      = done_g;
        assign error_a[gi]     = error_g;
        assign win_load_a[gi]  = win_load_g;
        assign eng_start_a[gi] = eng_start_g;
        assign out_valid_a[gi] = out_valid_g;
        assign wrow_a[gi]      = 3'(win_row_g);
        assign wcol_a[gi]      = 3'(win_col_g);
        assign orow_a[gi]      = 3'(out_row_g);
        assign ocol_a[gi]      = 3'(out_col_g);
        assign odata_a[gi]     = out_data_g;

        // Engine model (1-cycle latency) plus window-order check and scoreboard.
        initial begin
            int   load_idx;
            int   pr, pc;
            logic pend;
            logic [7:0] pdata;
            exp_t e;
            load_idx     = 0;
            pr           = 0;
            pc           = 0;
            pend         = 1'b0;
            pdata        = '0;
            eng_valid_g  = 1'b0;
            eng_result_g = '0;
            forever begin
                @(negedge clk);
                eng_valid_g = 1'b0;
                if (rst) begin
                    sb_q.delete();
                    load_idx = 0;
                    pend     = 1'b0;
                end else begin
                    if (pend) begin
                        eng_valid_g  = 1'b1;
                        eng_result_g = pdata;
                        sb_q.push_back('{r: 8'(pr), c: 8'(pc), d: pdata});
                        pend = 1'b0;
                    end
                    if (eng_start_g && !mute_a[gi]) begin
                        pend  = 1'b1;
                        pdata = 8'($urandom);
                    end
                    if (win_load_g) begin
                        pr = load_idx / OS;
                        pc = load_idx % OS;
                        check($sformatf("i%0d_win_row_w%0d", gi, load_idx), 32'(win_row_g), 32'(pr * STR));
                        check($sformatf("i%0d_win_col_w%0d", gi, load_idx), 32'(win_col_g), 32'(pc * STR));
                        load_idx++;
                    end
                    if (out_valid_g && out_ready_a[gi]) begin
                        check($sformatf("i%0d_sb_nonempty", gi), 32'(sb_q.size() > 0), 32'd1);
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            $display("i%0d out (%0d,%0d) data=%0d", gi, out_row_g, out_col_g, out_data_g);
                            check($sformatf("i%0d_out_row", gi), 32'(out_row_g), 32'(e.r));
                            check($sformatf("i%0d_out_col", gi), 32'(out_col_g), 32'(e.c));
                            check($sformatf("i%0d_out_data", gi), 32'(out_data_g), 32'(e.d));
                        end
                        out_cnt[gi]++;
                    end
                    if (done_g) begin
                        check($sformatf("i%0d_sb_empty_at_done", gi), 32'(sb_q.size()), 32'd0);
                        load_idx = 0;
                    end
                end
            end
        end
    end

    // One full pass; latency counts the start-sampling edge as edge 1.
    task automatic run_pass(input int inst, input bit mute, output int lat, output int es,
                            output logic busy1, output logic err1,
                            output logic busy_end, output logic err_end);
        mute_a[inst]  = mute;
        out_cnt[inst] = 0;
        @(posedge clk); #1;
        start_a[inst] = 1'b1;
        @(posedge clk); #1;
        start_a[inst] = 1'b0;
        lat   = 1;
        es    = 0;
        busy1 = busy_a[inst];
        err1  = error_a[inst];
        while (done_a[inst] !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (eng_start_a[inst] && es == 0) es = lat;
        end
        busy_end = busy_a[inst];
        err_end  = error_a[inst];
        mute_a[inst] = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        nerr++;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        int   lat, es, n, dones;
        logic b1, e1, be, ee, found;
        logic [7:0] held;

        tbl[0] = '{0, 1'b0, 102, 25, 1'b0};
        tbl[1] = '{1, 1'b0,  38,  9, 1'b0};
        tbl[2] = '{2, 1'b0,   6,  1, 1'b0};
        tbl[3] = '{0, 1'b1,  14,  0, 1'b1};
        tbl[4] = '{0, 1'b0, 102, 25, 1'b0};

        rst         = 1'b1;
        start_a     = '0;
        out_ready_a = '1;
        mute_a      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_error", 32'(error_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_win_load", 32'(win_load_a), 32'd0);
        check("rst_eng_start", 32'(eng_start_a), 32'd0);
        check("rst_win_row0", 32'(wrow_a[0]), 32'd0);
        check("rst_out_col0", 32'(ocol_a[0]), 32'd0);
        check("rst_out_data0", 32'(odata_a[0]), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_pass(tbl[i].inst, tbl[i].mute, lat, es, b1, e1, be, ee);
            $display("pass %0d inst=%0d mute=%0d lat=%0d outs=%0d err=%0d",
                     i, tbl[i].inst, tbl[i].mute, lat, out_cnt[tbl[i].inst], ee);
            check($sformatf("p%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("p%0d_busy_after_start", i), 32'(b1), 32'd1);
            check($sformatf("p%0d_error_cleared_by_start", i), 32'(e1), 32'd0);
            check($sformatf("p%0d_busy_at_done", i), 32'(be), 32'd0);
            check($sformatf("p%0d_error_at_done", i), 32'(ee), 32'(tbl[i].exp_err));
            check($sformatf("p%0d_outputs", i), 32'(out_cnt[tbl[i].inst]), 32'(tbl[i].exp_outs));
            if (tbl[i].mute) check($sformatf("p%0d_done_after_eng_start", i), 32'(lat - es), 32'd12);
        end

        // Sink stall on window (2,3) of instance 0.
        out_cnt[0] = 0;
        @(posedge clk); #1;
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk); #1;
            if (out_valid_a[0] && orow_a[0] == 3'd2 && ocol_a[0] == 3'd3) found = 1'b1;
        end
        check("stall_window_reached", 32'(found), 32'd1);
        out_ready_a[0] = 1'b0;
        held = odata_a[0];
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            $display("stall cycle %0d valid=%0d (%0d,%0d) data=%0d", k, out_valid_a[0], orow_a[0], ocol_a[0], odata_a[0]);
            check($sformatf("stall%0d_valid", k), 32'(out_valid_a[0]), 32'd1);
            check($sformatf("stall%0d_row", k), 32'(orow_a[0]), 32'd2);
            check($sformatf("stall%0d_col", k), 32'(ocol_a[0]), 32'd3);
            check($sformatf("stall%0d_data", k), 32'(odata_a[0]), 32'(held));
        end
        out_ready_a[0] = 1'b1;
        n = 0;
        while (done_a[0] !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_pass_done", 32'(done_a[0]), 32'd1);
        check("stall_pass_outputs", 32'(out_cnt[0]), 32'd25);

        // Reset during WAIT of window (1,1) on instance 0.
        @(posedge clk); #1;
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk); #1;
            if (eng_start_a[0] && wrow_a[0] == 3'd1 && wcol_a[0] == 3'd1) found = 1'b1;
        end
        check("rst_window_reached", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        $display("midpass reset busy=%0d valid=%0d done=%0d", busy_a[0], out_valid_a[0], done_a[0]);
        check("midrst_busy", 32'(busy_a[0]), 32'd0);
        check("midrst_out_valid", 32'(out_valid_a[0]), 32'd0);
        check("midrst_done", 32'(done_a[0]), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done_a[0]) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);

        run_pass(0, 1'b0, lat, es, b1, e1, be, ee);
        $display("restart pass lat=%0d outs=%0d", lat, out_cnt[0]);
        check("restart_latency", 32'(lat), 32'd102);
        check("restart_outputs", 32'(out_cnt[0]), 32'd25);
        check("restart_error", 32'(ee), 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequences a shared SIZEKER x SIZEKER convolution engine across a SIZE x SIZE input map.
- Generates window origins in raster order, pulses window-load and engine-start, and waits for the engine result.
- Forwards each result to a result sink through a valid/ready handshake.
- Sits between the top-level control (start/done) and the conv engine plus result buffer; replaces ad-hoc index/phase logic inside the convolution wrappers.

Parameters:
- SIZE, 7, input map edge length.
- SIZEKER, 3, kernel edge length; must be <= SIZE.
- STRIDE, 1, window step in rows and columns; must be >= 1.
- WIDTH_BIT, 8, width of engine result and output data.
- TIMEOUT, 255, maximum cycles to wait for eng_valid before error; must be >= 1.
- Derived localparams: OUT_SIZE = (SIZE-SIZEKER)/STRIDE+1; IDX_W = $clog2(SIZE).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a full map pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the pass completes or aborts.
- error  out  1  sticky engine-timeout flag; cleared by the next accepted start or by reset.
- win_row  out  IDX_W  row origin of the current window (input coordinates).
- win_col  out  IDX_W  column origin of the current window.
- win_load  out  1  one-cycle pulse; datapath latches the window at (win_row, win_col).
- eng_start  out  1  one-cycle pulse; engine begins MAC on the latched window.
- eng_valid  in  1  engine result valid; pulse or level.
- eng_result  in  WIDTH_BIT  engine output.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts the result.
- out_row  out  IDX_W  output-map row index (win_row/STRIDE).
- out_col  out  IDX_W  output-map column index.
- out_data  out  WIDTH_BIT  registered engine result.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; all outputs 0; row/col counters 0; timeout counter 0.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: on start go to LOAD. Clear error and row/col counters.
  - LOAD: assert win_load for 1 cycle; go to FIRE.
  - FIRE: assert eng_start for 1 cycle; clear the timeout counter; go to WAIT.
  - WAIT: on eng_valid capture eng_result into out_data; go to PUSH.
    - Otherwise increment the timeout counter.
    - When it reaches TIMEOUT: set error, go to DONE (abort).
  - PUSH: out_valid = 1; out_row/out_col/out_data stable until the handshake completes.
    - On out_valid && out_ready: drop out_valid.
    - If last window (row == OUT_SIZE-1 and col == OUT_SIZE-1): go to DONE.
    - Else advance the counters and go to LOAD.
  - DONE: pulse done for 1 cycle; go to IDLE.
- Counter advance: col increments; when col == OUT_SIZE-1, col wraps to 0 and row increments.
- win_row = row*STRIDE and win_col = col*STRIDE, held stable from LOAD through PUSH.
- Minimum per-window latency with a 1-cycle engine and out_ready tied high: 4 cycles (LOAD, FIRE, WAIT, PUSH).
- Full pass minimum latency = 4*OUT_SIZE^2 + 2 cycles from start to done.
- eng_valid outside WAIT is ignored.
- start outside IDLE is ignored; there is no queuing.
- out_ready low stalls in PUSH indefinitely; there is no timeout on the sink side.
- Reset mid-pass returns to IDLE in the same cycle. No done pulse; out_valid drops.
- OUT_SIZE == 1 (SIZE == SIZEKER): exactly one window, then DONE.

Optional Feature:
- Macro CONV_SCHED_PERF_EN.
- When defined:
  - Adds output port stall_cycles (32 bits). It counts cycles spent in WAIT plus cycles in PUSH with out_ready low.
  - The counter clears on an accepted start and saturates at all-ones.
  - It holds its value after done.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - the typedef enum for FSM states (IDLE, LOAD, FIRE, WAIT, PUSH, DONE);
  - the function computing OUT_SIZE;
  - the default WIDTH_BIT constant.
- One sub-module is natural: conv_window_counter, which holds the raster row/col counters with the advance/clear/last outputs and is reused by future pooling schedulers.

Test Plan:
- SIZE=7, SIZEKER=3, STRIDE=1, 1-cycle engine, out_ready=1 -> 25 outputs in raster order (0,0)..(4,4); done at cycle 102 after start; error=0.
- STRIDE=2, SIZE=7 -> OUT_SIZE=3; win_col sequence 0,2,4 per row; 9 outputs.
- out_ready toggled low for 5 cycles on window (2,3) -> out_valid held, out_data/out_row/out_col stable; no skipped or duplicated output.
- Engine never asserts eng_valid, TIMEOUT=10 -> error=1 and done pulse 12 cycles after eng_start; next start clears error.
- Reset asserted during WAIT of window (1,1) -> next cycle: state IDLE, busy=0, out_valid=0, no done; a new start restarts at (0,0).
- SIZE=3, SIZEKER=3 -> single window (0,0), one output, done.
